// File: rtl/seg_scan_decoder.sv
// Display monitor for a multiplexed 7-segment scan: recovers the four digits, blanks and
// decimal points from the an/seg/dp pins and publishes them as complete frames.
module seg_scan_decoder #(
    parameter int STABLE_CYC   = 4,
    parameter int SCAN_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    input  logic       dp,
    output logic [3:0] d_mt,
    output logic [3:0] d_mo,
    output logic [3:0] d_st,
    output logic [3:0] d_so,
    output logic [3:0] blank,
    output logic [3:0] dp_on,
    output logic       frame_valid,
    output logic       frame_chg,
    output logic       err_anode,
    output logic       err_pattern,
    output logic       stalled
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(SCAN_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
    localparam logic [TW-1:0] T_MAX   = TW'(SCAN_TIMEOUT);

    typedef enum logic {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

    // {blank, value}; unknown patterns decode to 4'hE
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: seg_decode = {1'b0, 4'd0};
            7'b1111001: seg_decode = {1'b0, 4'd1};
            7'b0100100: seg_decode = {1'b0, 4'd2};
            7'b0110000: seg_decode = {1'b0, 4'd3};
            7'b0011001: seg_decode = {1'b0, 4'd4};
            7'b0010010: seg_decode = {1'b0, 4'd5};
            7'b0000010: seg_decode = {1'b0, 4'd6};
            7'b1111000: seg_decode = {1'b0, 4'd7};
            7'b0000000: seg_decode = {1'b0, 4'd8};
            7'b0010000: seg_decode = {1'b0, 4'd9};
            7'b1111111: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = {1'b0, 4'hE};
        endcase
    endfunction

    // {valid, slot}
    function automatic logic [2:0] slot_decode(input logic [3:0] a);
        case (a)
            4'b1110: slot_decode = {1'b1, 2'd0};
            4'b1101: slot_decode = {1'b1, 2'd1};
            4'b1011: slot_decode = {1'b1, 2'd2};
            4'b0111: slot_decode = {1'b1, 2'd3};
            default: slot_decode = {1'b0, 2'd0};
        endcase
    endfunction

    logic [3:0]      s_an_q, prev_an_q;
    logic [6:0]      s_seg_q, prev_seg_q;
    logic            s_dp_q, prev_dp_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [1:0]      acc_slot_q, acc_slot_d;
    logic [3:0]      acc_val_q, acc_val_d;
    logic            acc_blank_q, acc_blank_d;
    logic            acc_dp_q, acc_dp_d;
    logic [3:0][3:0] sh_val_q, sh_val_d;
    logic [3:0]      sh_blank_q, sh_blank_d;
    logic [3:0]      sh_dp_q, sh_dp_d;
    logic [3:0]      seen_q, seen_d;
    state_t          state_q, state_d;
    logic [3:0][3:0] out_val_q, out_val_d;
    logic [3:0]      out_blank_q, out_blank_d;
    logic [3:0]      out_dp_q, out_dp_d;
    logic            fv_q, fv_d, chg_q, chg_d;
    logic            ea_q, ea_d, ep_q, ep_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            an_ok, an_bad, same;
    logic [1:0]      an_slot;

    always_comb begin
        {an_ok, an_slot} = slot_decode(s_an_q);
        an_bad = !an_ok && (s_an_q != 4'hF);
        same   = (s_an_q == prev_an_q) && (s_seg_q == prev_seg_q) && (s_dp_q == prev_dp_q);

        // cnt_q == 0 means the previous sample was idle or illegal
        cnt_d = '0;
        if (an_ok) begin
            if (cnt_q == '0 || !same)  cnt_d = CW'(1);
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            else                       cnt_d = cnt_q;
        end
        acc_d = an_ok && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        {acc_blank_d, acc_val_d} = seg_decode(s_seg_q);
        acc_slot_d = an_slot;
        acc_dp_d   = ~s_dp_q;

        sh_val_d   = sh_val_q;
        sh_blank_d = sh_blank_q;
        sh_dp_d    = sh_dp_q;
        seen_d     = (state_q == PUBLISH) ? 4'h0 : seen_q;
        if (acc_q) begin
            sh_val_d[acc_slot_q]   = acc_val_q;
            sh_blank_d[acc_slot_q] = acc_blank_q;
            sh_dp_d[acc_slot_q]    = acc_dp_q;
            seen_d[acc_slot_q]     = 1'b1;
        end
        state_d = (state_q == COLLECT && seen_d == 4'hF) ? PUBLISH : COLLECT;

        out_val_d   = out_val_q;
        out_blank_d = out_blank_q;
        out_dp_d    = out_dp_q;
        fv_d        = 1'b0;
        chg_d       = 1'b0;
        if (state_q == PUBLISH) begin
            out_val_d   = sh_val_q;
            out_blank_d = sh_blank_q;
            out_dp_d    = sh_dp_q;
            fv_d        = 1'b1;
            chg_d       = {sh_val_q, sh_blank_q, sh_dp_q} != {out_val_q, out_blank_q, out_dp_q};
        end

        ea_d   = an_bad;
        ep_d   = acc_q && (acc_val_q == 4'hE);
        tcnt_d = acc_q ? '0 : ((tcnt_q == T_MAX) ? tcnt_q : tcnt_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an_q      <= 4'hF;
            s_seg_q     <= 7'h7F;
            s_dp_q      <= 1'b1;
            prev_an_q   <= 4'hF;
            prev_seg_q  <= 7'h7F;
            prev_dp_q   <= 1'b1;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            acc_slot_q  <= '0;
            acc_val_q   <= '0;
            acc_blank_q <= 1'b0;
            acc_dp_q    <= 1'b0;
            sh_val_q    <= '0;
            sh_blank_q  <= 4'hF;
            sh_dp_q     <= '0;
            seen_q      <= '0;
            state_q     <= COLLECT;
            out_val_q   <= '0;
            out_blank_q <= 4'hF;
            out_dp_q    <= '0;
            fv_q        <= 1'b0;
            chg_q       <= 1'b0;
            ea_q        <= 1'b0;
            ep_q        <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            s_an_q      <= an;
            s_seg_q     <= seg;
            s_dp_q      <= dp;
            prev_an_q   <= s_an_q;
            prev_seg_q  <= s_seg_q;
            prev_dp_q   <= s_dp_q;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_slot_q  <= acc_slot_d;
            acc_val_q   <= acc_val_d;
            acc_blank_q <= acc_blank_d;
            acc_dp_q    <= acc_dp_d;
            sh_val_q    <= sh_val_d;
            sh_blank_q  <= sh_blank_d;
            sh_dp_q     <= sh_dp_d;
            seen_q      <= seen_d;
            state_q     <= state_d;
            out_val_q   <= out_val_d;
            out_blank_q <= out_blank_d;
            out_dp_q    <= out_dp_d;
            fv_q        <= fv_d;
            chg_q       <= chg_d;
            ea_q        <= ea_d;
            ep_q        <= ep_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign d_mt        = out_val_q[3];
    assign d_mo        = out_val_q[2];
    assign d_st        = out_val_q[1];
    assign d_so        = out_val_q[0];
    assign blank       = out_blank_q;
    assign dp_on       = out_dp_q;
    assign frame_valid = fv_q;
    assign frame_chg   = chg_q;
    assign err_anode   = ea_q;
    assign err_pattern = ep_q;
    assign stalled     = (tcnt_q == T_MAX);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: vector table of full scans plus hand sequences for
// short dwells, anode errors, reset mid-frame and scan timeout.
module tb_seg_scan_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an = 4'hF;
    logic       dp = 1'b1;
    logic [3:0] d_mt, d_mo, d_st, d_so, blank, dp_on;
    logic       frame_valid, frame_chg, err_anode, err_pattern, stalled;

    seg_scan_decoder #(.STABLE_CYC(4), .SCAN_TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .dp(dp),
        .d_mt(d_mt), .d_mo(d_mo), .d_st(d_st), .d_so(d_so),
        .blank(blank), .dp_on(dp_on), .frame_valid(frame_valid), .frame_chg(frame_chg),
        .err_anode(err_anode), .err_pattern(err_pattern), .stalled(stalled)
    );

    always #5 clk = ~clk;

    int   errs = 0, checks = 0;
    int   fv_n = 0, ea_n = 0, ep_n = 0, step_no = 0, fv_at = 0, last_start = 0;
    logic last_chg = 1'b0;

    typedef struct {
        logic [15:0] digs;
        logic [3:0]  dpm;
        logic [15:0] exp_d;
        logic [3:0]  exp_blank;
        logic [3:0]  exp_dp;
        logic        exp_chg;
        int          exp_ep;
    } vec_t;
    vec_t vt[4];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;
            4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;
            4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;
            4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;
            4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0010000;
            4'hE: seg_of = 7'b0101010;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        fv_n = 0; ea_n = 0; ep_n = 0;
    endtask

    task automatic step();
        @(negedge clk);
        step_no++;
        if (frame_valid === 1'b1) begin
            fv_n++;
            last_chg = frame_chg;
            fv_at = step_no;
        end
        if (err_anode === 1'b1) ea_n++;
        if (err_pattern === 1'b1) ep_n++;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; seg = s; dp = d;
        repeat (n) step();
    endtask

    task automatic scan(input logic [15:0] digs, input logic [3:0] dpm, input logic [3:0] mask,
                        input int dwell, input int gap);
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) begin
                last_start = step_no;
                drive(~(4'b0001 << k), seg_of(digs[k*4 +: 4]), ~dpm[k], dwell);
                if (gap > 0) drive(4'hF, 7'h7F, 1'b1, gap);
            end
        end
        drive(4'hF, 7'h7F, 1'b1, 4);
    endtask

    initial begin
        int k0;
        int first;
        vt[0] = '{16'h1234, 4'h0, 16'h1234, 4'h0, 4'h0, 1'b1, 0};
        vt[1] = '{16'h1234, 4'h0, 16'h1234, 4'h0, 4'h0, 1'b0, 0};
        vt[2] = '{16'h9058, 4'b0101, 16'h9058, 4'h0, 4'b0101, 1'b1, 0};
        vt[3] = '{16'h7FE6, 4'h0, 16'h7FE6, 4'b0100, 4'h0, 1'b1, 1};

        // reset state
        drive(4'hF, 7'h7F, 1'b1, 3);
        chk("rst_d", 32'({d_mt, d_mo, d_st, d_so}), 32'h0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_dp_on", 32'(dp_on), 32'h0);
        chk("rst_stalled", 32'(stalled), 32'h0);
        chk("rst_fv", 32'(fv_n), 32'h0);
        rst_n = 1'b1;

        // full scans from the table
        for (int i = 0; i < 4; i++) begin
            clr();
            scan(vt[i].digs, vt[i].dpm, 4'hF, 10, 0);
            chk($sformatf("v%0d_fv_count", i), 32'(fv_n), 32'd1);
            chk($sformatf("v%0d_latency", i), 32'(fv_at - last_start), 32'd7);
            chk($sformatf("v%0d_digits", i), 32'({d_mt, d_mo, d_st, d_so}), 32'(vt[i].exp_d));
            chk($sformatf("v%0d_blank", i), 32'(blank), 32'(vt[i].exp_blank));
            chk($sformatf("v%0d_dp_on", i), 32'(dp_on), 32'(vt[i].exp_dp));
            chk($sformatf("v%0d_chg", i), 32'(last_chg), 32'(vt[i].exp_chg));
            chk($sformatf("v%0d_err_pattern", i), 32'(ep_n), 32'(vt[i].exp_ep));
        end

        // dwell of STABLE_CYC-1 never accepts
        clr();
        drive(4'b1110, seg_of(4'd5), 1'b1, 3);
        drive(4'b1110, seg_of(4'd6), 1'b1, 3);
        drive(4'b1101, seg_of(4'd7), 1'b1, 3);
        drive(4'b1011, seg_of(4'd7), 1'b1, 3);
        drive(4'b0111, seg_of(4'd7), 1'b1, 3);
        drive(4'hF, 7'h7F, 1'b1, 4);
        chk("short_fv", 32'(fv_n), 32'd0);
        scan(16'h2468, 4'h0, 4'b1110, 10, 0);
        chk("short_seen", 32'(fv_n), 32'd0);
        scan(16'h2468, 4'h0, 4'b0001, 10, 0);
        chk("short_fv_after", 32'(fv_n), 32'd1);
        chk("short_digits", 32'({d_mt, d_mo, d_st, d_so}), 32'h2468);

        // multiple anodes low, then idle gaps
        clr();
        drive(4'b1100, seg_of(4'd3), 1'b1, 5);
        drive(4'hF, 7'h7F, 1'b1, 4);
        chk("anode_err", 32'(ea_n), 32'd5);
        chk("anode_fv", 32'(fv_n), 32'd0);
        clr();
        scan(16'h1357, 4'h0, 4'hF, 10, 3);
        chk("gap_err", 32'(ea_n), 32'd0);
        chk("gap_fv", 32'(fv_n), 32'd1);
        chk("gap_digits", 32'({d_mt, d_mo, d_st, d_so}), 32'h1357);

        // reset after three slots
        clr();
        scan(16'h8642, 4'h0, 4'b1110, 10, 0);
        chk("mid_fv", 32'(fv_n), 32'd0);
        rst_n = 1'b0;
        step(); step();
        chk("mid_rst_d", 32'({d_mt, d_mo, d_st, d_so}), 32'h0);
        chk("mid_rst_blank", 32'(blank), 32'hF);
        chk("mid_rst_dp_on", 32'(dp_on), 32'h0);
        rst_n = 1'b1;
        clr();
        scan(16'h5319, 4'h0, 4'b0001, 10, 0);
        chk("post_rst_partial", 32'(fv_n), 32'd0);
        scan(16'h5319, 4'h0, 4'b1110, 10, 0);
        chk("post_rst_fv", 32'(fv_n), 32'd1);
        chk("post_rst_digits", 32'({d_mt, d_mo, d_st, d_so}), 32'h5319);

        // scan timeout
        drive(4'hF, 7'h7F, 1'b1, 2);
        k0 = step_no;
        drive(4'b1110, seg_of(4'd5), 1'b1, 5);
        an = 4'hF; seg = 7'h7F;
        first = -1;
        for (int n = 0; n < 100 && first < 0; n++) begin
            step();
            if (stalled === 1'b1) first = step_no - k0;
        end
        chk("stall_latency", 32'(first), 32'd56);
        an = 4'b1101; seg = seg_of(4'd7);
        repeat (5) step();
        chk("stall_hold", 32'(stalled), 32'd1);
        step();
        chk("stall_clear", 32'(stalled), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
